// File: rtl/halt_dump_if.sv
// Secondary read ports into data memory and register file,
// used by the halt dump engine.
interface halt_dump_if;
    logic [7:0]  mem_rd_addr;
    logic        mem_rd_en;
    logic [15:0] mem_rd_data;
    logic [3:0]  reg_rd_addr;
    logic        reg_rd_en;
    logic [15:0] reg_rd_data;

    modport master (
        output mem_rd_addr, mem_rd_en,
        output reg_rd_addr, reg_rd_en,
        input  mem_rd_data, reg_rd_data
    );

    modport slave (
        input  mem_rd_addr, mem_rd_en,
        input  reg_rd_addr, reg_rd_en,
        output mem_rd_data, reg_rd_data
    );
endinterface

// File: rtl/halt_dump_tx.sv
// On CPU halt, dumps data memory then the register file as a framed
// byte stream on an 8N1 UART line.
module halt_dump_tx #(
    parameter int          DATA_DEPTH   = 16,
    parameter int          REG_COUNT    = 10,
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  HDR          = 8'hA5,
    parameter logic [7:0]  TRL          = 8'h5A
) (
    input  logic         CLK,
    input  logic         rst,
    input  logic         do_halt,
    halt_dump_if.master  rd,
    output logic         tx,
    output logic         busy,
    output logic         done
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [7:0] MEM_LAST = 8'(DATA_DEPTH - 1);
    localparam logic [7:0] REG_LAST = 8'(REG_COUNT - 1);

    typedef enum logic [3:0] {
        IDLE, SEND_HDR, RD_MEM, LAT_MEM, SEND_HI,
        SEND_LO, RD_REG, LAT_REG, SEND_TRL, FIN
    } state_t;

    state_t        state;
    logic          prev;
    logic [7:0]    idx;
    logic [15:0]   shadow;
    logic          is_reg;
    logic          tx_act;
    logic [7:0]    sh;
    logic [3:0]    bit_cnt;
    logic [BW-1:0] baud;

    logic       halt_evt;
    logic       in_send;
    logic       tx_start;
    logic       byte_end;
    logic [7:0] tx_byte;

    assign halt_evt = prev & ~do_halt;
    assign in_send  = (state == SEND_HDR) || (state == SEND_HI) ||
                      (state == SEND_LO)  || (state == SEND_TRL);
    assign tx_start = in_send & ~tx_act;
    assign byte_end = tx_act && (bit_cnt == 4'd9) && (baud == BAUD_LAST);

    always_comb begin
        tx_byte = TRL;
        unique case (state)
            SEND_HDR: tx_byte = HDR;
            SEND_HI:  tx_byte = shadow[15:8];
            SEND_LO:  tx_byte = shadow[7:0];
            default:  tx_byte = TRL;
        endcase
    end

    always_ff @(posedge CLK) begin
        prev <= do_halt;
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            tx             <= 1'b1;
            tx_act         <= 1'b0;
            sh             <= '0;
            bit_cnt        <= '0;
            baud           <= '0;
            idx            <= '0;
            shadow         <= '0;
            is_reg         <= 1'b0;
            rd.mem_rd_en   <= 1'b0;
            rd.mem_rd_addr <= '0;
            rd.reg_rd_en   <= 1'b0;
            rd.reg_rd_addr <= '0;
        end else begin
            done         <= 1'b0;
            rd.mem_rd_en <= 1'b0;
            rd.reg_rd_en <= 1'b0;

            // bit_cnt: 0 start, 1..8 data, 9 stop
            if (tx_start) begin
                tx      <= 1'b0;
                tx_act  <= 1'b1;
                sh      <= tx_byte;
                bit_cnt <= '0;
                baud    <= '0;
            end else if (tx_act) begin
                if (baud == BAUD_LAST) begin
                    baud    <= '0;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd9) begin
                        tx_act <= 1'b0;
                    end else if (bit_cnt == 4'd8) begin
                        tx <= 1'b1;
                    end else begin
                        tx <= sh[0];
                        sh <= {1'b0, sh[7:1]};
                    end
                end else begin
                    baud <= baud + 1'b1;
                end
            end

            unique case (state)
                IDLE: if (halt_evt) begin
                    state <= SEND_HDR;
                    busy  <= 1'b1;
                end
                SEND_HDR: if (byte_end) begin
                    idx            <= '0;
                    is_reg         <= 1'b0;
                    rd.mem_rd_en   <= 1'b1;
                    rd.mem_rd_addr <= '0;
                    state          <= RD_MEM;
                end
                RD_MEM: state <= LAT_MEM;
                LAT_MEM: begin
                    shadow <= rd.mem_rd_data;
                    state  <= SEND_HI;
                end
                RD_REG: state <= LAT_REG;
                LAT_REG: begin
                    shadow <= rd.reg_rd_data;
                    state  <= SEND_HI;
                end
                SEND_HI: if (byte_end) state <= SEND_LO;
                SEND_LO: if (byte_end) begin
                    if (!is_reg && idx < MEM_LAST) begin
                        idx            <= idx + 8'd1;
                        rd.mem_rd_en   <= 1'b1;
                        rd.mem_rd_addr <= idx + 8'd1;
                        state          <= RD_MEM;
                    end else if (!is_reg) begin
                        idx            <= '0;
                        is_reg         <= 1'b1;
                        rd.reg_rd_en   <= 1'b1;
                        rd.reg_rd_addr <= '0;
                        state          <= RD_REG;
                    end else if (idx < REG_LAST) begin
                        idx            <= idx + 8'd1;
                        rd.reg_rd_en   <= 1'b1;
                        rd.reg_rd_addr <= 4'(idx + 8'd1);
                        state          <= RD_REG;
                    end else begin
                        state <= SEND_TRL;
                    end
                end
                SEND_TRL: if (byte_end) state <= FIN;
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/halt_dump_tx.md
Name: halt_dump_tx

Overview:
- Readout engine for the 16-bit CPU.
- When the core halts, it reads data memory words 0..DATA_DEPTH-1 and then register file entries 0..REG_COUNT-1.
- It serialises them, framed, onto a single 8N1 UART transmit line, so a board or bench can capture final machine state without hierarchical peeking.
- Sits beside the memory and decode stages, on secondary read ports.

Parameters:
- DATA_DEPTH, 16, number of data-memory words dumped (1..256).
- REG_COUNT, 10, number of registers dumped (1..16).
- CLKS_PER_BIT, 868, CLK cycles per UART bit (>=2).
- HDR, 8'hA5, frame header byte.
- TRL, 8'h5A, frame trailer byte.

Ports:
- CLK  input  1  system clock; all logic on posedge.
- rst  input  1  reset: one clock; synchronous, active-high.
- do_halt  input  1  CPU halt status; a 1->0 transition is the halt event that starts a dump.
- mem_rd_addr  output  8  data-memory read address.
- mem_rd_en  output  1  data-memory read strobe.
- mem_rd_data  input  16  word for the address strobed on the previous cycle.
- reg_rd_addr  output  4  register read address.
- reg_rd_en  output  1  register read strobe.
- reg_rd_data  input  16  register value for the address strobed on the previous cycle.
- tx  output  1  UART serial out; idle high.
- busy  output  1  high from the halt event until the trailer stop bit ends.
- done  output  1  one-cycle pulse after the trailer stop bit.

Behaviour:
- Reset values: tx=1, busy=0, done=0, mem_rd_en=0, reg_rd_en=0, addresses=0, FSM=IDLE, do_halt edge register loaded with the current do_halt.
- Halt detection:
  - Registered previous do_halt; event = prev & ~do_halt.
  - Events while busy are ignored.
  - The event is accepted in the cycle it is detected; busy rises on the next edge.
- FSM states: IDLE, SEND_HDR, RD_MEM, LAT_MEM, SEND_HI, SEND_LO, RD_REG, LAT_REG, SEND_TRL, FIN.
  - IDLE -> SEND_HDR on event.
  - SEND_HDR: transmit HDR, then go to RD_MEM with index=0.
  - RD_MEM: drive mem_rd_en=1 and mem_rd_addr=index for exactly one cycle, then go to LAT_MEM.
  - LAT_MEM: capture mem_rd_data into a 16-bit shadow word, then go to SEND_HI.
  - SEND_HI: transmit shadow[15:8].
  - SEND_LO: transmit shadow[7:0].
    - If index < DATA_DEPTH-1: increment index and return to RD_MEM.
    - Else: clear index and go to RD_REG.
  - RD_REG / LAT_REG mirror the memory path using the reg port and REG_COUNT; after the last register's low byte, go to SEND_TRL.
  - SEND_TRL: transmit TRL, then go to FIN.
  - FIN: pulse done for one cycle, drop busy, return to IDLE.
- Byte transmitter:
  - Shared 8N1 serialiser: start bit 0, data bits LSB first, stop bit 1.
  - Each bit held exactly CLKS_PER_BIT cycles.
  - A byte occupies 10*CLKS_PER_BIT cycles.
  - The next byte's start bit may follow the stop bit; gaps of up to 3 cycles (read latency) between bytes are allowed; tx stays high in any gap.
- Frame: 2 + 2*(DATA_DEPTH+REG_COUNT) bytes; 54 with the default parameters.
- Each word is sampled once; later changes to memory or registers during the dump do not affect already-captured words.
- Counters: bit counter 4 bits, baud counter clog2(CLKS_PER_BIT) bits, index 8 bits. Index stops at the last entry; no wrap.
- rst asserted mid-dump: abort immediately; tx returns high on the next edge (a truncated frame is acceptable); all outputs take their reset values; no done pulse.
- A do_halt 0->1->0 sequence during a dump is not queued; a new dump starts only from a halt event seen in IDLE.
- mem_rd_en and reg_rd_en are never high in the same cycle.

Test Plan:
- Reset, then hold do_halt=1 for 10 cycles -> tx=1, busy=0, no read strobes.
- DATA_DEPTH=4, REG_COUNT=2, CLKS_PER_BIT=4, memory={1,100,16'h1234,0}, regs={16'hBEEF,624}; drop do_halt -> UART decodes A5 00 01 00 64 12 34 00 00 BE EF 02 70 5A; done pulses once; busy deasserts the same cycle done pulses.
- Bit timing: CLKS_PER_BIT=4, single byte A5 -> tx low for exactly 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high.
- Second do_halt falling edge mid-frame -> frame identical to the uninterrupted case; no second frame.
- rst asserted after byte 5 -> tx=1 next cycle, busy=0, no done; a subsequent halt event produces a complete, correct frame.
- Defaults (16/10): capture the frame and count bytes -> 54; regs[1]=624 appears as bytes 02 70 at frame offsets 35-36.
